uart_tx_ctrl: RTL and testbench

UART transmit controller: accepts a parallel byte over a valid/busy handshake and sequences the frame (start bit, data bits LSB first, optional parity, stop bit) onto a single serial line, one bit per clock. It sits beside the parity calculator in the UART TX path. It drives the `busy` the parity calculator uses to qualify its data latch, and selects that calculator's `par_bit` into the frame. The serializer shift register and the output bit mux are internal to this block.

---
 rtl/uart_tx_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer (start, data LSB first, optional parity, stop)
`timescale 1ns/1ps
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state_q,  state_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q,     tx_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are computed for the next state so the line bit is registered
  // and lands in the same cycle the state register enters that state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid) begin
          state_d  = ST_START;
          shift_d  = P_DATA;
          par_en_d = PAR_EN;
          cnt_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end

      ST_DATA: begin
        if (cnt_q == LAST_IDX) begin
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = 1'b1;
      end

      ST_STOP: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized self-checking bench for uart_tx_ctrl against a frame-list model
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  logic       Clk;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       par_bit;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .Clk        (Clk),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Reference: the serial line is simply start 0, data LSB first, parity if enabled, stop 1.
  function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pb,
                                      output logic bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(1'b1);
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pb);
    @(negedge Clk);
    P_DATA     = d;
    PAR_EN     = pe;
    par_bit    = pb;
    Data_Valid = 1'b1;
  endtask

  // Called right after the accept negedge; checks every frame cycle plus the trailing IDLE cycle.
  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic dv_after, input bit pulse5);
    logic bits[$];
    build_frame(d, pe, pb, bits);
    for (int k = 1; k <= bits.size(); k++) begin
      @(negedge Clk);
      check($sformatf("tx_k%0d", k), 32'(TX_OUT), 32'(bits[k-1]));
      check($sformatf("busy_k%0d", k), 32'(busy), 32'd1);
      check($sformatf("done_k%0d", k), 32'(frame_done), 32'd0);
      if (k == 1) begin
        Data_Valid = dv_after;
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
      end
      if (pulse5 && k == 5) Data_Valid = 1'b1;
      if (pulse5 && k == 6) Data_Valid = 1'b0;
    end
    @(negedge Clk);
    check("idle_tx", 32'(TX_OUT), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(frame_done), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("quiet_tx", 32'(TX_OUT), 32'd1);
      check("quiet_busy", 32'(busy), 32'd0);
      check("quiet_done", 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pe, pb;
    logic       bits[$];

    RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; par_bit = 1'b0;
    #1;
    check("rst_tx", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    @(negedge Clk); @(negedge Clk);
    RST = 1'b0;
    idle_cycles(2);

    // A5 without parity
    start_frame(8'hA5, 1'b0, 1'b0);
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // 81 with parity, both parity bit values
    start_frame(8'h81, 1'b1, 1'b0);
    expect_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    start_frame(8'h81, 1'b1, 1'b1);
    expect_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);

    // Data_Valid held: 0F then F0 with one idle cycle between
    start_frame(8'h0F, 1'b0, 1'b0);
    expect_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    P_DATA = 8'hF0; PAR_EN = 1'b0; par_bit = 1'b0;
    expect_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    // Data_Valid pulse mid-frame is ignored
    start_frame(8'h3C, 1'b1, 1'b1);
    expect_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cycles(3);

    // Asynchronous reset at cycle 6 of a frame
    start_frame(8'hC3, 1'b0, 1'b0);
    build_frame(8'hC3, 1'b0, 1'b0, bits);
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      check($sformatf("pre_rst_tx_k%0d", k), 32'(TX_OUT), 32'(bits[k-1]));
      if (k == 1) Data_Valid = 1'b0;
    end
    #1 RST = 1'b1;
    #1;
    check("async_rst_tx", 32'(TX_OUT), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(frame_done), 32'd0);
    @(negedge Clk);
    check("rst_hold_done", 32'(frame_done), 32'd0);
    RST = 1'b0;
    idle_cycles(2);
    start_frame(8'h5A, 1'b1, 1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pb = 1'($urandom);
      start_frame(d, pe, pb);
      expect_frame(d, pe, pb, 1'b0, bit'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
